// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter: MEM has priority over IF, multi-byte accesses are split
// into consecutive byte transfers and read data is reassembled little-endian.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rstn_in,
    input  logic              rdy_in,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic              flush_in,
    output logic              if_stall,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;       // 1 = MEM, 0 = IF
    logic              wr_q, wr_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       data_cap;
    logic [1:0]        rx_idx;
    logic [ADDR_W-1:0] ram_addr_d;
    logic              ram_wr_d;
    logic [7:0]        ram_dout_d;
    logic [31:0]       if_inst_d, mem_rdata_d;

    function automatic logic [2:0] len_to_n(input logic [1:0] len);
        case (len)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
        return w[8*k +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[8*k +: 8] = b;
        return r;
    endfunction

    // Byte returned in this cycle was addressed two counts ago (RAM has one cycle latency).
    assign rx_idx = cnt_q[1:0] - 2'd2;

    assign if_done   = (state_q == S_DONE) && !owner_q;
    assign mem_done  = (state_q == S_DONE) && owner_q;
    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        ram_addr_d  = ram_addr;
        ram_wr_d    = ram_wr;
        ram_dout_d  = ram_dout;
        if_inst_d   = if_inst;
        mem_rdata_d = mem_rdata;
        data_cap    = put_byte(data_q, rx_idx, ram_din);

        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    owner_d    = 1'b1;
                    wr_d       = mem_wr;
                    n_d        = len_to_n(mem_len);
                    base_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    data_d     = 32'd0;
                    ram_addr_d = mem_addr;
                    ram_wr_d   = mem_wr;
                    ram_dout_d = mem_wdata[7:0];
                    cnt_d      = 3'd1;
                    state_d    = S_BUSY;
                end else if (if_req && !flush_in) begin
                    owner_d    = 1'b0;
                    wr_d       = 1'b0;
                    n_d        = 3'd4;
                    base_d     = if_addr;
                    data_d     = 32'd0;
                    ram_addr_d = if_addr;
                    ram_wr_d   = 1'b0;
                    cnt_d      = 3'd1;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (!owner_q && flush_in) begin
                    ram_wr_d = 1'b0;
                    cnt_d    = 3'd0;
                    state_d  = S_IDLE;
                end else if (wr_q) begin
                    if (cnt_q < n_q) begin
                        ram_addr_d = base_q + ADDR_W'(cnt_q);
                        ram_dout_d = byte_of(wdata_q, cnt_q[1:0]);
                        ram_wr_d   = 1'b1;
                        cnt_d      = cnt_q + 3'd1;
                    end else begin
                        ram_wr_d = 1'b0;
                        state_d  = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q < n_q)
                        ram_addr_d = base_q + ADDR_W'(cnt_q);
                    if (cnt_q >= 3'd2)
                        data_d = data_cap;
                    if (cnt_q == n_q + 3'd1) begin
                        state_d = S_DONE;
                        if (owner_q)
                            mem_rdata_d = data_cap;
                        else
                            if_inst_d = data_cap;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            wr_q      <= 1'b0;
            n_q       <= 3'd0;
            cnt_q     <= 3'd0;
            base_q    <= '0;
            wdata_q   <= 32'd0;
            data_q    <= 32'd0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
            if_inst   <= 32'd0;
            mem_rdata <= 32'd0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wr_q      <= wr_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            ram_addr  <= ram_addr_d;
            ram_wr    <= ram_wr_d;
            ram_dout  <= ram_dout_d;
            if_inst   <= if_inst_d;
            mem_rdata <= mem_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus hand-written contention,
// flush, ready-freeze and reset sequences against a byte-wide RAM model.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    logic              clk_in = 1'b0;
    logic              rstn_in, rdy_in;
    logic              if_req, mem_req, mem_wr, flush_in;
    logic [ADDR_W-1:0] if_addr, mem_addr;
    logic [1:0]        mem_len;
    logic [31:0]       mem_wdata;
    logic              if_done, mem_done, if_stall, mem_stall, ram_wr;
    logic [31:0]       if_inst, mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din = 8'd0;

    logic [7:0]  ram [0:65535];
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'd0;
    logic [7:0]  pre_data = 8'd0;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        is_if;
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  lat;
        logic [31:0] rdata;
    } txn_t;

    txn_t tv [12];

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_in(clk_in), .rstn_in(rstn_in), .rdy_in(rdy_in),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .flush_in(flush_in), .if_stall(if_stall), .mem_stall(mem_stall),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk_in = ~clk_in;

    // RAM model shares the global ready, so its read pipeline freezes with the arbiter.
    always @(posedge clk_in) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (rdy_in) begin
            if (ram_wr)
                ram[ram_addr[15:0]] <= ram_dout;
            ram_din <= ram[ram_addr[15:0]];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk_in);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(posedge clk_in);
        #1;
        pre_we   = 1'b0;
    endtask

    task automatic run_txn(input txn_t t, input string nm);
        int          done_c;
        int          wr_cnt;
        int          n;
        logic        spurious;
        logic [31:0] got;
        done_c   = -1;
        wr_cnt   = 0;
        spurious = 1'b0;
        got      = 32'd0;
        n = (t.len == 2'b00) ? 1 : (t.len == 2'b01) ? 2 : 4;
        if (t.is_if) begin
            if_req  = 1'b1;
            if_addr = t.addr;
        end else begin
            mem_req   = 1'b1;
            mem_wr    = t.wr;
            mem_len   = t.len;
            mem_addr  = t.addr;
            mem_wdata = t.wdata;
        end
        for (int c = 0; c < 20 && done_c < 0; c++) begin
            @(negedge clk_in);
            if (c == 0)
                chk({nm, "_stall0"}, 32'(t.is_if ? if_stall : mem_stall), 32'd1);
            if (ram_wr) begin
                wr_cnt++;
                chk({nm, "_waddr"}, ram_addr, t.addr + 32'(c - 1));
                chk({nm, "_wbyte"}, 32'(ram_dout), (t.wdata >> (8 * (c - 1))) & 32'hFF);
            end
            if (t.is_if ? mem_done : if_done)
                spurious = 1'b1;
            if (t.is_if ? if_done : mem_done) begin
                done_c = c;
                got = t.is_if ? if_inst : mem_rdata;
                chk({nm, "_stall_done"}, 32'(t.is_if ? if_stall : mem_stall), 32'd0);
            end
            next_cycle;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        mem_wr  = 1'b0;
        chk({nm, "_latency"}, 32'(done_c), 32'(t.lat));
        if (!t.wr)
            chk({nm, "_rdata"}, got, t.rdata);
        chk({nm, "_wr_cycles"}, 32'(wr_cnt), t.wr ? 32'(n) : 32'd0);
        chk({nm, "_other_done"}, 32'(spurious), 32'd0);
    endtask

    initial begin
        int md;
        int id;
        int wrs;
        int ifd;

        tv[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0,          8'd6, 32'h0050_0093};
        tv[1]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0020, 32'hDEAD_BEEF,  8'd5, 32'h0};
        tv[2]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0041, 32'h0,          8'd4, 32'h0000_FF80};
        tv[3]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0008, 32'h0,          8'd3, 32'h0000_005A};
        tv[4]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0020, 32'h0,          8'd6, 32'hDEAD_BEEF};
        tv[5]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0030, 32'hCAFE_F00D,  8'd5, 32'h0};
        tv[6]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0030, 32'h1234_5699,  8'd2, 32'h0};
        tv[7]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0032, 32'hFFFF_BEEF,  8'd3, 32'h0};
        tv[8]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0030, 32'h0,          8'd6, 32'hBEEF_F099};
        tv[9]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0021, 32'h0,          8'd4, 32'h0000_ADBE};
        tv[10] = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFF, 32'h0,          8'd6, 32'h4433_2211};
        tv[11] = '{1'b0, 1'b0, 2'b00, 32'h0000_0023, 32'h0,          8'd3, 32'h0000_00DE};

        rstn_in = 1'b0;  rdy_in = 1'b1;  flush_in = 1'b0;
        if_req = 1'b0;   if_addr = '0;
        mem_req = 1'b0;  mem_wr = 1'b0;  mem_len = 2'b00;  mem_addr = '0;  mem_wdata = 32'd0;

        poke(16'h1000, 8'h93);  poke(16'h1001, 8'h00);
        poke(16'h1002, 8'h50);  poke(16'h1003, 8'h00);
        poke(16'h0041, 8'h80);  poke(16'h0042, 8'hFF);
        poke(16'h0008, 8'h5A);
        poke(16'hFFFF, 8'h11);  poke(16'h0000, 8'h22);
        poke(16'h0001, 8'h33);  poke(16'h0002, 8'h44);

        @(negedge clk_in);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_done", 32'({if_done, mem_done}), 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        next_cycle;
        rstn_in = 1'b1;

        for (int i = 0; i < 12; i++)
            run_txn(tv[i], $sformatf("txn%0d", i));

        // Word fetch, cycle by cycle
        if_req = 1'b1;
        if_addr = 32'h1000;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk_in);
            if (c >= 1 && c <= 4)
                chk($sformatf("fetch_addr_c%0d", c), ram_addr, 32'h1000 + 32'(c - 1));
            if (c <= 5)
                chk($sformatf("fetch_stall_c%0d", c), 32'(if_stall), 32'd1);
            chk($sformatf("fetch_done_c%0d", c), 32'(if_done), 32'(c == 6));
            if (c == 6)
                chk("fetch_inst", if_inst, 32'h0050_0093);
            next_cycle;
        end
        if_req = 1'b0;

        // Contention: MEM first, IF one idle-sample cycle after mem_done
        if_req = 1'b1;  if_addr = 32'h1000;
        mem_req = 1'b1; mem_wr = 1'b0; mem_len = 2'b00; mem_addr = 32'h8;
        md = -1;
        id = -1;
        for (int c = 0; c <= 14 && id < 0; c++) begin
            @(negedge clk_in);
            if (c == 0) begin
                chk("cont_if_stall0", 32'(if_stall), 32'd1);
                chk("cont_mem_stall0", 32'(mem_stall), 32'd1);
            end
            if (c == 5)
                chk("cont_if_first_addr", ram_addr, 32'h1000);
            if (mem_done && md < 0) begin
                md = c;
                chk("cont_mem_rdata", mem_rdata, 32'h5A);
            end
            if (if_done && id < 0) begin
                id = c;
                chk("cont_if_inst", if_inst, 32'h0050_0093);
            end
            next_cycle;
            if (md == c) mem_req = 1'b0;
            if (id == c) if_req = 1'b0;
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        chk("cont_mem_done_cycle", 32'(md), 32'd3);
        chk("cont_if_done_cycle", 32'(id), 32'd10);

        // Flush mid-fetch, then a MEM request proves the arbiter is idle in cycle 3
        if_req = 1'b1;
        if_addr = 32'h1000;
        md = -1;
        wrs = 0;
        ifd = 0;
        for (int c = 0; c <= 9; c++) begin
            if (c == 2) flush_in = 1'b1;
            if (c == 3) begin
                flush_in = 1'b0;  if_req = 1'b0;
                mem_req = 1'b1;   mem_wr = 1'b0;  mem_len = 2'b00;  mem_addr = 32'h41;
            end
            @(negedge clk_in);
            if (ram_wr) wrs++;
            if (if_done) ifd++;
            if (c == 4)
                chk("flush_mem_addr_c4", ram_addr, 32'h41);
            if (mem_done && md < 0) begin
                md = c;
                chk("flush_mem_rdata", mem_rdata, 32'h80);
            end
            next_cycle;
            if (md == c) mem_req = 1'b0;
        end
        mem_req = 1'b0;
        chk("flush_mem_done_cycle", 32'(md), 32'd6);
        chk("flush_ram_wr_cycles", 32'(wrs), 32'd0);
        chk("flush_if_done_count", 32'(ifd), 32'd0);

        // rdy_in low for three cycles inside a word fetch
        if_req = 1'b1;
        if_addr = 32'h1000;
        id = -1;
        for (int c = 0; c <= 15 && id < 0; c++) begin
            if (c == 3) rdy_in = 1'b0;
            if (c == 6) rdy_in = 1'b1;
            @(negedge clk_in);
            if (c == 6)
                chk("rdy_addr_held", ram_addr, 32'h1002);
            if (if_done) begin
                id = c;
                chk("rdy_if_inst", if_inst, 32'h0050_0093);
            end
            next_cycle;
            if (id == c) if_req = 1'b0;
        end
        if_req = 1'b0;
        rdy_in = 1'b1;
        chk("rdy_done_cycle", 32'(id), 32'd9);

        // Asynchronous reset in the middle of a word store
        mem_req = 1'b1;  mem_wr = 1'b1;  mem_len = 2'b10;
        mem_addr = 32'h50;  mem_wdata = 32'h0102_0304;
        @(negedge clk_in);
        next_cycle;
        @(negedge clk_in);
        chk("mrst_wr_before", 32'(ram_wr), 32'd1);
        next_cycle;
        @(negedge clk_in);
        rstn_in = 1'b0;
        #1;
        chk("mrst_ram_addr", ram_addr, 32'd0);
        chk("mrst_ram_wr", 32'(ram_wr), 32'd0);
        chk("mrst_ram_dout", 32'(ram_dout), 32'd0);
        chk("mrst_done", 32'({if_done, mem_done}), 32'd0);
        chk("mrst_if_inst", if_inst, 32'd0);
        chk("mrst_mem_rdata", mem_rdata, 32'd0);
        mem_req = 1'b0;
        mem_wr = 1'b0;
        next_cycle;
        rstn_in = 1'b1;
        run_txn('{1'b0, 1'b0, 2'b00, 32'h41, 32'h0, 8'd3, 32'h80}, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-wide RAM port between the instruction-fetch requester (IF) and the load/store requester (MEM).
- Serializes each 1/2/4-byte access into consecutive byte transfers and reassembles little-endian words.
- Returns one-cycle done pulses to the requesters.
- Drives the stall signals that freeze the IF/ID and later pipeline registers while a requester waits.

## Interface
Parameters:
- ADDR_W, 32, address width for requester and RAM addresses.

Ports:
- clk_in  in  1  clock; all state updates on rising edge.
- rstn_in  in  1  reset. Asynchronous and active-low, so the block is in reset while low.
- rdy_in  in  1  global ready; low freezes all state.
- if_req  in  1  IF requests a word read; held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_done  out  1  one-cycle pulse; if_inst valid in the same cycle.
- if_inst  out  32  fetched word.
- mem_req  in  1  MEM requests an access; held until mem_done.
- mem_wr  in  1  1 = store, 0 = load.
- mem_len  in  2  00 = byte, 01 = half, 10/11 = word.
- mem_addr  in  ADDR_W  access address.
- mem_wdata  in  32  store data; low bytes are used first.
- mem_done  out  1  one-cycle pulse; mem_rdata valid in the same cycle for loads.
- mem_rdata  out  32  load data, zero-extended; the MEM stage sign-extends.
- flush_in  in  1  branch redirect; cancels a pending or in-flight IF access.
- if_stall  out  1  if_req & ~if_done (combinational); drives the IF/ID block input.
- mem_stall  out  1  mem_req & ~mem_done (combinational).
- ram_addr  out  ADDR_W  registered RAM byte address.
- ram_wr  out  1  registered RAM write enable.
- ram_dout  out  8  registered RAM write byte.
- ram_din  in  8  RAM read byte, valid one cycle after its address was driven.

## Operation
- States: IDLE, BUSY, DONE. Registers: owner (IF/MEM), N (byte count 1/2/4), cnt (3 bits), base address, assembled data.
- IDLE, arbitration:
  - mem_req wins over if_req.
  - IF is granted only if mem_req=0 and flush_in=0.
  - On grant: latch owner/addr/len/wdata; ram_addr<=addr; ram_wr<=wr; ram_dout<=wdata[7:0]; cnt<=1; go BUSY.
- BUSY, read (IF, or MEM with mem_wr=0):
  - While cnt<N: ram_addr<=base+cnt, cnt++.
  - Every BUSY cycle after the first, ram_din is captured into bits [8(k)+7:8k] for byte k = transfer index being returned.
  - After the last byte is captured, go DONE.
- BUSY, write:
  - While cnt<N: ram_addr<=base+cnt, ram_dout<=wdata[8cnt+7:8cnt], ram_wr<=1, cnt++.
  - When cnt=N: ram_wr<=0, go DONE.
- DONE:
  - Pulse the owner's done; other done stays 0.
  - Requests are not sampled; next state IDLE.
- Unused high bytes of mem_rdata are 0.
- Address arithmetic wraps modulo 2^ADDR_W.
- flush_in=1 while owner=IF in BUSY: ram_wr stays 0, state goes IDLE at the next edge, no if_done. flush_in has no effect on a MEM access.
- rdy_in=0: state, cnt, data and RAM outputs hold. The cycle is not counted, and ram_din is not captured in that cycle.
- Reset (rstn_in low), all registers cleared:
  - State IDLE, cnt 0.
  - ram_addr 0, ram_wr 0, ram_dout 0.
  - if_done 0, mem_done 0, if_inst 0, mem_rdata 0.
  - Reset mid-access abandons the access with no done.

## Timing
- Request sampled in IDLE at cycle 0; first RAM address in cycle 1.
- Read of N bytes: addresses in cycles 1..N, data in cycles 2..N+1. Done in cycle N+2, so a word fetch finishes in cycle 6 and a byte load in cycle 3.
- Write of N bytes: ram_wr=1 in cycles 1..N, done in cycle N+1.
- Requester sees done in cycle D and may change its request at the edge ending D. Arbiter is IDLE in D+1 and samples then, giving back-to-back grants with one idle-sample cycle.
- Both requests in the same IDLE cycle: MEM is served, IF waits. IF is granted in the IDLE cycle after mem_done if mem_req=0 then.
- if_stall/mem_stall have zero latency from the req/done inputs.

## Test plan
- Word fetch:
  - Stimulus: RAM[0x1000..0x1003]=93 00 50 00; if_req with if_addr=0x1000 from cycle 0.
  - Response: ram_addr 0x1000..0x1003 in cycles 1-4; if_done only in cycle 6 with if_inst=0x00500093; if_stall=1 in cycles 0-5.
- Store word:
  - Stimulus: mem_req, mem_wr=1, len=10, addr=0x20, wdata=0xDEADBEEF.
  - Response: ram_wr=1 with bytes EF,BE,AD,DE at 0x20..0x23 in cycles 1-4; mem_done in cycle 5.
- Half load:
  - Stimulus: RAM[0x41]=0x80, RAM[0x42]=0xFF; load len=01 at 0x41.
  - Response: mem_rdata=0x0000FF80 with mem_done in cycle 4.
- Contention:
  - Stimulus: if_req and mem_req (byte load at 0x8) both raised in cycle 0.
  - Response: MEM is served, mem_done in cycle 3; IF granted in cycle 4, if_done in cycle 10.
- Flush mid-fetch:
  - Stimulus: flush_in pulsed in cycle 2 of a fetch; ram_wr monitored.
  - Response: ram_wr stays 0 throughout, state is IDLE in cycle 3, and if_done never asserts.
- rdy_in freeze and mid-write reset:
  - rdy_in=0 for 3 cycles inside a word fetch: if_done slips exactly 3 cycles and the data is unchanged.
  - rstn_in low mid-write: all outputs go to 0 immediately, and the next request starts from IDLE.
